alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised successor to the combinational ALU-control decoder. It decodes `{alu_op, funct7, funct3}` and executes the full RV32I/RV64I integer ALU set plus, optionally, the M-extension multiply/divide group. Single-cycle ops and iterative multi-cycle mul/div share one valid/ready handshake with a registered result. The block sits in the execute stage between the main control unit and the writeback/branch logic.

## Interface
- `XLEN`, default 32: datapath width. Must be a power of two, 8 or more.
- `MUL_EN`, default 1: 1 enables M-extension ops; 0 makes every M encoding illegal.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset. One clock domain; reset is asynchronous and active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: the block accepts a request this cycle. High only in IDLE.
- `alu_op` in 2: from Control. 00 = add (ld/sd), 01 = sub (branch), 10 = R-type, 11 = I-type.
- `funct7` in 7: instruction bits 31:25.
- `funct3` in 3: instruction bits 14:12.
- `op_a` in XLEN: rs1 operand.
- `op_b` in XLEN: rs2 or immediate operand.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered result.
- `zero` out 1: registered flag, `result == 0`.
- `illegal` out 1: registered flag, the encoding is unsupported.

## Operation
- Accept: a request is accepted when `in_valid && in_ready`. All inputs are sampled on that edge.
- Decode for `alu_op` 10:
  - `funct7` 0000000 selects, by `funct3` 0..7: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - `funct7` 0100000 with `funct3` 000 selects SUB; with 101 selects SRA.
  - `funct7` 0000001 (only when MUL_EN=1) selects, by `funct3` 0..7: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Decode for `alu_op` 11:
  - `funct3` 000/010/011/100/110/111 select ADDI, SLTI, SLTIU, XORI, ORI, ANDI; `funct7` is ignored for these.
  - 001 requires `funct7[6:1]` all zero for SLLI.
  - 101 with `funct7[5]`=0 selects SRLI, with `funct7[5]`=1 selects SRAI; all other `funct7` bits must be zero.
- `alu_op` 00 forces ADD and `alu_op` 01 forces SUB, regardless of the funct fields.
- Any other encoding is illegal: `result`=0, `illegal`=1, and it completes with single-cycle latency.
- Shift amount is `op_b[log2(XLEN)-1:0]`. SLT/SLTI compare signed and SLTU/SLTIU compare unsigned; both return 0 or 1.
- Multiply:
  - Shift-add, one bit per cycle, XLEN iterations on a 2·XLEN product.
  - MUL returns the low half. MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - Signed handling is done by operand-magnitude conversion with a final conditional negate.
- Divide:
  - Restoring division, one quotient bit per cycle, XLEN iterations, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Divide special cases are resolved at accept with single-cycle latency and no iteration:
  - Divisor 0: quotient all-ones, remainder = `op_a`.
  - Signed overflow (`op_a` = −2^(XLEN−1), `op_b` = −1): quotient = `op_a`, remainder 0.
- `zero` reflects the final `result` for every op, including M ops and illegal encodings.

## Timing
- States and transitions:
  - IDLE → CALC on accepting an iterative mul/div.
  - IDLE → DONE on accepting any other op.
  - CALC → DONE when the iteration counter reaches XLEN−1.
  - DONE → IDLE on `out_valid && out_ready`.
- Latency, counted from the accept edge to the first cycle `out_valid`=1:
  - 1 cycle for ALU ops, illegal encodings and divide special cases.
  - XLEN+1 cycles for iterative mul/div.
- `in_ready` = (state == IDLE). There is no back-to-back issue; the earliest next accept is the cycle after the result handshake.
- `out_valid` = (state == DONE).
- `result`, `zero` and `illegal` hold stable while `out_valid`=1 and `out_ready`=0 (backpressure of any length).
- `in_valid` during CALC or DONE is ignored; the upstream stage must hold it.
- Reset values: state IDLE, `out_valid` 0, `in_ready` 1 (combinational from state), `result` 0, `zero` 0, `illegal` 0, iteration counter 0.
- Asserting `rst_n` low mid-CALC or mid-DONE aborts the operation immediately. No `out_valid` is produced for it.
- The iteration counter is log2(XLEN) bits wide and clears on every accept.

## Test plan
- ALU sweep, XLEN=32:
  - `alu_op`=10, `funct7`=0100000, `funct3`=101, `op_a`=0x80000000, `op_b`=4 → SRA, `result`=0xF8000000 at accept+1.
  - Same operands with `funct7`=0 → SRL, `result`=0x08000000.
  - `alu_op`=01, `op_a`=`op_b`=5 → `zero`=1.
- Multiply:
  - MULH with `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → `result`=0x00000000.
  - MULHU with the same operands → `result`=0xFFFFFFFE.
  - Both must show `out_valid` exactly 33 cycles after accept.
- Divide edge cases:
  - DIV 7 / 0 → `result`=0xFFFFFFFF.
  - REM 7 / 0 → `result`=7.
  - DIV 0x80000000 / 0xFFFFFFFF → `result`=0x80000000.
  - All three must reach `out_valid` at accept+1. Separately, DIV −7 / 2 → −3 and REM −7 / 2 → −1.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `result` must stay stable and `in_ready` must stay 0 throughout.
  - Release `out_ready` → handshake; `in_ready`=1 on the next cycle.
- Illegal encodings:
  - With MUL_EN=0, `funct7`=0000001, `funct3`=000 (MUL) → `illegal`=1, `result`=0, `zero`=1.
  - `alu_op`=11, `funct3`=001, `funct7`=0100000 → `illegal`=1.
- Reset abort: start DIVU, drop `rst_n` at cycle 10 of CALC.
  - `out_valid`=0 and `in_ready`=1 immediately, asynchronously.
  - `result`=0.
  - No spurious `out_valid` after reset is released.

Source files
------------

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : Execute-stage integer unit. Decodes {alu_op, funct7, funct3}
//             and runs the RV32I/RV64I ALU set plus, when MUL_EN=1, the
//             M-extension multiply/divide group. ALU ops, illegal encodings
//             and divide special cases complete in one cycle; regular
//             mul/div iterate one bit per cycle. All share one valid/ready
//             handshake with a registered result.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             in_valid_i/in_ready_o   - request handshake (ready only in IDLE)
//             alu_op_i, funct7_i, funct3_i - operation encoding
//             op_a_i, op_b_i    - rs1 and rs2/immediate operands
//             out_valid_o/out_ready_i - result handshake
//             result_o, zero_o, illegal_o - registered result and flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int                c_SHW      = $clog2(XLEN);
    localparam logic [c_SHW-1:0]  c_CNT_LAST = {c_SHW{1'b1}};          // XLEN-1
    localparam logic [c_SHW-1:0]  c_CNT_ONE  = {{(c_SHW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17,
        OP_ILL    = 5'd18
    } op_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic [c_SHW-1:0]  cnt_q;
    op_t               op_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [XLEN-1:0]   acc_q;    // mul: running high half / div: partial remainder
    logic [XLEN-1:0]   lo_q;     // mul: multiplier->low half / div: dividend->quotient
    logic [XLEN-1:0]   opd_q;    // mul: multiplicand magnitude / div: divisor magnitude
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              illegal_q;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    op_t w_op;

    always_comb begin
        w_op = OP_ILL;
        case (alu_op_i)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (funct7_i == 7'b0000000) begin
                    case (funct3_i)
                        3'd0:    w_op = OP_ADD;
                        3'd1:    w_op = OP_SLL;
                        3'd2:    w_op = OP_SLT;
                        3'd3:    w_op = OP_SLTU;
                        3'd4:    w_op = OP_XOR;
                        3'd5:    w_op = OP_SRL;
                        3'd6:    w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (funct7_i == 7'b0100000) begin
                    if (funct3_i == 3'd0) begin
                        w_op = OP_SUB;
                    end else if (funct3_i == 3'd5) begin
                        w_op = OP_SRA;
                    end
                end else if ((funct7_i == 7'b0000001) && (MUL_EN != 0)) begin
                    case (funct3_i)
                        3'd0:    w_op = OP_MUL;
                        3'd1:    w_op = OP_MULH;
                        3'd2:    w_op = OP_MULHSU;
                        3'd3:    w_op = OP_MULHU;
                        3'd4:    w_op = OP_DIV;
                        3'd5:    w_op = OP_DIVU;
                        3'd6:    w_op = OP_REM;
                        default: w_op = OP_REMU;
                    endcase
                end
            end
            default: begin
                case (funct3_i)
                    3'd0: w_op = OP_ADD;
                    3'd1: if (funct7_i[6:1] == 6'd0) w_op = OP_SLL;
                    3'd2: w_op = OP_SLT;
                    3'd3: w_op = OP_SLTU;
                    3'd4: w_op = OP_XOR;
                    3'd5: begin
                        // funct7[5] picks arithmetic; every other bit must be clear
                        if ({funct7_i[6], funct7_i[4:0]} == 6'd0) begin
                            w_op = funct7_i[5] ? OP_SRA : OP_SRL;
                        end
                    end
                    3'd6:    w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------------
    logic [c_SHW-1:0] w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [XLEN-1:0]  w_alu_res;

    assign w_shamt = op_b_i[c_SHW-1:0];
    assign w_lt_s  = $signed(op_a_i) < $signed(op_b_i);
    assign w_lt_u  = op_a_i < op_b_i;

    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_ADD:  w_alu_res = op_a_i + op_b_i;
            OP_SUB:  w_alu_res = op_a_i - op_b_i;
            OP_SLL:  w_alu_res = op_a_i << w_shamt;
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            OP_XOR:  w_alu_res = op_a_i ^ op_b_i;
            OP_SRL:  w_alu_res = op_a_i >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(op_a_i) >>> w_shamt);
            OP_OR:   w_alu_res = op_a_i | op_b_i;
            OP_AND:  w_alu_res = op_a_i & op_b_i;
            default: w_alu_res = '0;   // M ops and illegal encodings
        endcase
    end

    // ------------------------------------------------------------------------
    // Mul/div classification, special cases and operand magnitudes
    // ------------------------------------------------------------------------
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_op_rem;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic            w_iter;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN-1:0] w_fast_res;

    assign w_is_mul   = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                        (w_op == OP_MULHSU) || (w_op == OP_MULHU);
    assign w_is_div   = (w_op == OP_DIV) || (w_op == OP_DIVU) ||
                        (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_op_rem   = (w_op == OP_REM) || (w_op == OP_REMU);
    // MUL only uses the low half, which is sign-agnostic; treat it as signed.
    assign w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_b_signed = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                        (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_neg_a    = w_a_signed && op_a_i[XLEN-1];
    assign w_neg_b    = w_b_signed && op_b_i[XLEN-1];
    // Negating the most-negative value yields itself, which is the correct
    // unsigned magnitude 2^(XLEN-1).
    assign w_mag_a    = w_neg_a ? -op_a_i : op_a_i;
    assign w_mag_b    = w_neg_b ? -op_b_i : op_b_i;

    assign w_div_zero = (op_b_i == '0);
    assign w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (op_a_i == c_MIN) && (op_b_i == '1);
    assign w_special  = w_is_div && (w_div_zero || w_div_ovf);
    assign w_iter     = (w_is_mul || w_is_div) && !w_special;

    always_comb begin
        w_fast_res = w_alu_res;
        if (w_is_div) begin
            if (w_div_zero) begin
                w_fast_res = w_op_rem ? op_a_i : '1;
            end else begin
                // signed overflow: quotient = dividend, remainder = 0
                w_fast_res = w_op_rem ? '0 : op_a_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // One iteration step (shift-add multiply / restoring divide)
    // ------------------------------------------------------------------------
    logic            w_calc_mul;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] acc_d;
    logic [XLEN-1:0] lo_d;

    assign w_calc_mul = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                        (op_q == OP_MULHSU) || (op_q == OP_MULHU);
    assign w_mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign w_div_sh   = {acc_q, lo_q[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, opd_q};
    // The partial remainder stays below the divisor, so a borrow out of the
    // top bit is exactly "shifted remainder < divisor".
    assign w_div_ge   = ~w_div_diff[XLEN];

    always_comb begin
        if (w_calc_mul) begin
            acc_d = w_mul_sum[XLEN:1];
            lo_d  = {w_mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            acc_d = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], w_div_ge};
        end
    end

    // Final sign correction and half/quotient/remainder select, applied to
    // the value produced by the last iteration.
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_calc_res;

    assign w_prod   = {acc_d, lo_d};
    assign w_prod_s = (neg_a_q ^ neg_b_q) ? -w_prod : w_prod;
    assign w_quo    = (neg_a_q ^ neg_b_q) ? -lo_d : lo_d;
    assign w_rem    = neg_a_q ? -acc_d : acc_d;

    always_comb begin
        case (op_q)
            OP_MUL:                       w_calc_res = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_res = w_quo;
            default:                      w_calc_res = w_rem;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        cnt_q   <= '0;
                        op_q    <= w_op;
                        neg_a_q <= w_neg_a;
                        neg_b_q <= w_neg_b;
                        if (w_iter) begin
                            state_q <= S_CALC;
                            acc_q   <= '0;
                            lo_q    <= w_is_mul ? w_mag_b : w_mag_a;
                            opd_q   <= w_is_mul ? w_mag_a : w_mag_b;
                        end else begin
                            state_q   <= S_DONE;
                            result_q  <= w_fast_res;
                            zero_q    <= (w_fast_res == '0);
                            illegal_q <= (w_op == OP_ILL);
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + c_CNT_ONE;
                    if (cnt_q == c_CNT_LAST) begin
                        state_q   <= S_DONE;
                        result_q  <= w_calc_res;
                        zero_q    <= (w_calc_res == '0);
                        illegal_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mdu
//  Purpose  : Self-checking bench for alu_mdu (XLEN=32). One instance with
//             MUL_EN=1, one with MUL_EN=0. Expected values are pushed to a
//             scoreboard queue at accept and popped when out_valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic        in_valid1;
    logic        in_valid0;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_ready;

    logic        in_ready1, out_valid1, zero1, illegal1;
    logic [31:0] result1;
    logic        in_ready0, out_valid0, zero0, illegal0;
    logic [31:0] result0;

    logic        sel0;
    logic        m_ir, m_ov, m_zero, m_ill;
    logic [31:0] m_res;

    int n_checks;
    int n_fail;
    logic [33:0] exp_q[$];   // {result, zero, illegal}

    alu_mdu #(.XLEN(32), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .alu_op_i(alu_op), .funct7_i(funct7), .funct3_i(funct3),
        .op_a_i(op_a), .op_b_i(op_b),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .result_o(result1), .zero_o(zero1), .illegal_o(illegal1)
    );

    alu_mdu #(.XLEN(32), .MUL_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .alu_op_i(alu_op), .funct7_i(funct7), .funct3_i(funct3),
        .op_a_i(op_a), .op_b_i(op_b),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .result_o(result0), .zero_o(zero0), .illegal_o(illegal0)
    );

    assign m_ir   = sel0 ? in_ready0  : in_ready1;
    assign m_ov   = sel0 ? out_valid0 : out_valid1;
    assign m_res  = sel0 ? result0    : result1;
    assign m_zero = sel0 ? zero0      : zero1;
    assign m_ill  = sel0 ? illegal0   : illegal1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: RV32IM semantics using native 64-bit arithmetic.
    function automatic logic [33:0] ref_model(input bit men, input logic [1:0] aop,
                                              input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        r;
        logic               ill;
        logic [4:0]         sh;
        logic signed [31:0] sa, sb;
        logic signed [63:0] xa, xb, pu;
        logic [63:0]        p;
        logic               ovf;
        r = '0; ill = 1'b0; sh = b[4:0]; sa = a; sb = b;
        xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; pu = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (aop == 2'b00) r = a + b;
        else if (aop == 2'b01) r = a - b;
        else if (aop == 2'b10 && f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << sh;
                3'd2: r = {31'd0, sa < sb};
                3'd3: r = {31'd0, a < b};
                3'd4: r = a ^ b;
                3'd5: r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (aop == 2'b10 && f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (aop == 2'b10 && f7 == 7'h20 && f3 == 3'd5) r = sa >>> sh;
        else if (aop == 2'b10 && f7 == 7'h01 && men) begin
            case (f3)
                3'd0: begin p = xa * xb; r = p[31:0]; end
                3'd1: begin p = xa * xb; r = p[63:32]; end
                3'd2: begin p = xa * pu; r = p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : sa / sb);
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : sa % sb);
                default: r = (b == 0) ? a : a % b;
            endcase
        end else if (aop == 2'b11) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: if (f7[6:1] == 6'd0) r = a << sh; else ill = 1'b1;
                3'd2: r = {31'd0, sa < sb};
                3'd3: r = {31'd0, a < b};
                3'd4: r = a ^ b;
                3'd5: if ({f7[6], f7[4:0]} == 6'd0) r = f7[5] ? (sa >>> sh) : (a >> sh);
                      else ill = 1'b1;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else ill = 1'b1;
        if (ill) r = '0;
        return {r, (r == 32'd0), ill};
    endfunction

    function automatic int ref_lat(input bit men, input logic [1:0] aop, input logic [6:0] f7,
                                   input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!(men && aop == 2'b10 && f7 == 7'h01)) return 1;
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op, check latency and result, optionally hold out_ready low
    // for `hold` cycles, then finish the handshake.
    task automatic do_op(input bit s0, input logic [1:0] aop, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [33:0] exp, input int lat, input int hold, input string tag);
        int n;
        logic [33:0] e;
        e = exp;
        sel0 = s0;
        @(negedge clk);
        out_ready = (hold == 0);
        check({tag, ".in_ready"}, m_ir, 1);
        alu_op = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        if (s0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        n = 1;
        while (!m_ov && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".latency"}, n, lat);
        if (m_ov) begin
            e = exp_q.pop_front();
            check({tag, ".result"},  m_res,  e[33:2]);
            check({tag, ".zero"},    m_zero, e[1]);
            check({tag, ".illegal"}, m_ill,  e[0]);
        end else begin
            exp_q.delete();
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".bp_result"},   m_res, e[33:2]);
            check({tag, ".bp_in_ready"}, m_ir,  0);
            check({tag, ".bp_valid"},    m_ov,  1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".post_in_ready"},  m_ir, 1);
        check({tag, ".post_out_valid"}, m_ov, 0);
    endtask

    initial begin
        logic [1:0]  aop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        seen;
        n_checks = 0; n_fail = 0;
        sel0 = 1'b0;
        rst_n = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
        alu_op = '0; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready",  in_ready1,  1);
        check("reset.out_valid", out_valid1, 0);
        check("reset.result",    result1,    0);
        check("reset.zero",      zero1,      0);
        check("reset.illegal",   illegal1,   0);
        @(negedge clk); rst_n = 1'b1;

        // ALU directed cases
        do_op(0, 2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, {32'hF800_0000, 1'b0, 1'b0}, 1, 0, "sra");
        do_op(0, 2'b10, 7'h00, 3'd5, 32'h8000_0000, 32'd4, {32'h0800_0000, 1'b0, 1'b0}, 1, 0, "srl");
        do_op(0, 2'b01, 7'h00, 3'd0, 32'd5, 32'd5, {32'd0, 1'b1, 1'b0}, 1, 0, "sub_zero");
        // Multiply
        do_op(0, 2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 1'b1, 1'b0}, 33, 0, "mulh");
        do_op(0, 2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 1'b0, 1'b0}, 33, 0, "mulhu");
        // Divide special cases and signed division
        do_op(0, 2'b10, 7'h01, 3'd4, 32'd7, 32'd0, {32'hFFFF_FFFF, 1'b0, 1'b0}, 1, 0, "div_by0");
        do_op(0, 2'b10, 7'h01, 3'd6, 32'd7, 32'd0, {32'd7, 1'b0, 1'b0}, 1, 0, "rem_by0");
        do_op(0, 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 1'b0, 1'b0}, 1, 0, "div_ovf");
        do_op(0, 2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 1'b0, 1'b0}, 33, 0, "div_neg");
        do_op(0, 2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 1'b0, 1'b0}, 33, 0, "rem_neg");
        // Illegal encodings
        do_op(1, 2'b10, 7'h01, 3'd0, 32'd3, 32'd4, {32'd0, 1'b1, 1'b1}, 1, 0, "mul_disabled");
        do_op(0, 2'b11, 7'h20, 3'd1, 32'd3, 32'd4, {32'd0, 1'b1, 1'b1}, 1, 0, "slli_bad");
        // Backpressure on an iterative op: DIVU 1000/7 = 142
        do_op(0, 2'b10, 7'h01, 3'd5, 32'd1000, 32'd7, {32'd142, 1'b0, 1'b0}, 33, 10, "backpressure");

        // Randomised encodings and operands against the reference model
        for (int k = 0; k < 30; k++) begin
            aop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            do_op(0, aop, f7, f3, a, b, ref_model(1'b1, aop, f7, f3, a, b),
                  ref_lat(1'b1, aop, f7, f3, a, b), 0, "rand");
        end

        // Reset abort in the middle of an iterative DIVU (previous result 142)
        do_op(0, 2'b10, 7'h01, 3'd5, 32'd1000, 32'd7, {32'd142, 1'b0, 1'b0}, 33, 0, "pre_abort");
        sel0 = 1'b0;
        @(negedge clk);
        alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("abort.busy_before", in_ready1, 0);
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", out_valid1, 0);
        check("abort.in_ready",  in_ready1,  1);
        check("abort.result",    result1,    0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid1) seen = 1'b1;
        end
        check("abort.no_valid", seen, 0);
        check("abort.idle", in_ready1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
